sopc_run_ctrl: RTL and testbench

Run controller for the min-SOPC: sequences core reset release, drives a per-hart halt request vector, and enforces a cycle-budget watchdog. It sits between the bench/host and `openmips_min_sopc`, replacing hand-timed reset and halt stimulus with a command-driven, synthesizable block. Generalised to `HARTS` halt channels, a configurable reset-hold length and budget, and a single-step mode that releases selected harts for an exact number of cycles.

---
 rtl/sopc_run_ctrl_pkg.sv | 21 ++
 rtl/sopc_run_ctrl_watchdog.sv | 42 ++++
 rtl/sopc_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_sopc_run_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// Shared encodings for the SOPC run controller: reset levels, command op codes
// and controller state encodings.
package sopc_run_ctrl_pkg;

  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;

  typedef logic [1:0] rc_op_t;
  typedef logic [1:0] rc_state_t;

  localparam rc_op_t CmdHalt   = 2'b00;
  localparam rc_op_t CmdResume = 2'b01;
  localparam rc_op_t CmdStep   = 2'b10;
  localparam rc_op_t CmdReset  = 2'b11;

  localparam rc_state_t RcHold = 2'b00;
  localparam rc_state_t RcRun  = 2'b01;
  localparam rc_state_t RcStep = 2'b10;
  localparam rc_state_t RcDone = 2'b11;

endpackage

// File: rtl/sopc_run_ctrl_watchdog.sv
// Run-cycle counter with saturation and a sticky budget watchdog.
// 'hit' flags the edge on which the count reaches the budget so the FSM can react on that same edge.
module run_watchdog
  import sopc_run_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = 500,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             fire,
  output logic             hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign hit = (MAX_CYCLES != 0) && en && (cnt != LIMIT) && (sat_inc(cnt) == LIMIT);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt  <= '0;
      fire <= 1'b0;
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= sat_inc(cnt);
      end
      if (hit) begin
        fire <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sopc_run_ctrl.sv
// Command-driven run controller for the min-SOPC: reset sequencing, per-hart
// halt requests, single-step release and a cycle-budget watchdog.
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int HARTS      = 2,
  parameter int RST_CYCLES = 10,
  parameter int MAX_CYCLES = 500,
  parameter int CNT_W      = 32,
  parameter int STEP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [HARTS-1:0]  cmd_mask,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              core_rst,
  output logic [HARTS-1:0]  halt_req,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              busy,
  output logic              timeout
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  rc_state_t         state;
  rc_state_t         state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [STEP_W-1:0] step_cnt;
  logic [STEP_W-1:0] step_cnt_nxt;
  logic [HARTS-1:0]  step_mask;
  logic [HARTS-1:0]  step_mask_nxt;
  logic [HARTS-1:0]  halt_nxt;
  logic              accept;
  logic              wd_en;
  logic              wd_clr;
  logic              wd_hit;

  assign accept = cmd_valid & cmd_ready;
  // Cycles count only while the core is out of reset and the budget has not expired.
  assign wd_en  = (state == RcRun) || (state == RcStep);

  run_watchdog #(
    .MAX_CYCLES (MAX_CYCLES),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .cnt  (cycle_cnt),
    .fire (timeout),
    .hit  (wd_hit)
  );

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_cnt;
    step_cnt_nxt  = step_cnt;
    step_mask_nxt = step_mask;
    halt_nxt      = halt_req;
    wd_clr        = 1'b0;
    if (wd_hit) begin
      state_nxt = RcDone;
      halt_nxt  = '1;
    end else begin
      case (state)
        RcHold: begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = RcRun;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end
        RcStep: begin
          if (step_cnt <= STEP_W'(1)) begin
            state_nxt = RcRun;
            halt_nxt  = halt_req | step_mask;
          end else begin
            step_cnt_nxt = step_cnt - 1'b1;
          end
        end
        RcRun: begin
          if (accept) begin
            case (cmd_op)
              CmdHalt:   halt_nxt = halt_req | cmd_mask;
              CmdResume: halt_nxt = halt_req & ~cmd_mask;
              CmdStep: begin
                // A zero-length step is a no-op and leaves the harts untouched.
                if (cmd_arg != '0) begin
                  halt_nxt      = halt_req & ~cmd_mask;
                  step_cnt_nxt  = cmd_arg;
                  step_mask_nxt = cmd_mask;
                  state_nxt     = RcStep;
                end
              end
              default: begin
                halt_nxt  = '0;
                hold_nxt  = '0;
                wd_clr    = 1'b1;
                state_nxt = RcHold;
              end
            endcase
          end
        end
        default: begin
          halt_nxt = '1;
          if (accept && (cmd_op == CmdReset)) begin
            halt_nxt  = '0;
            hold_nxt  = '0;
            wd_clr    = 1'b1;
            state_nxt = RcHold;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state     <= RcHold;
      hold_cnt  <= '0;
      halt_req  <= '0;
      core_rst  <= 1'b1;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      halt_req  <= halt_nxt;
      core_rst  <= (state_nxt == RcHold);
      cmd_ready <= (state_nxt == RcRun) || (state_nxt == RcDone);
      busy      <= (state_nxt != RcRun);
    end
  end

  // Step length and mask are only consulted in STEP, so they carry no reset.
  always_ff @(posedge clk) begin
    step_cnt  <= step_cnt_nxt;
    step_mask <= step_mask_nxt;
  end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Directed bench for sopc_run_ctrl with a 20-cycle budget so the watchdog is reachable.
module tb_sopc_run_ctrl;
  import sopc_run_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_mask = 2'b00;
  logic [7:0]  cmd_arg = 8'd0;
  logic        core_rst;
  logic [1:0]  halt_req;
  logic [31:0] cycle_cnt;
  logic        busy;
  logic        timeout;

  int n_chk  = 0;
  int n_fail = 0;

  sopc_run_ctrl #(
    .HARTS      (2),
    .RST_CYCLES (10),
    .MAX_CYCLES (20),
    .CNT_W      (32),
    .STEP_W     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_arg   (cmd_arg),
    .core_rst  (core_rst),
    .halt_req  (halt_req),
    .cycle_cnt (cycle_cnt),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] mask, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (core_rst && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_halt"}, 32'(halt_req), 32'd0);
    chk({tag, "_cnt"}, cycle_cnt, 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int n;
    int bad;

    // Reset release and basic halt control
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_vals("rst");
    rst = 1'b0;
    wait_release(n);
    chk("hold_len", 32'(n), 32'd10);
    chk("rel_ready", 32'(cmd_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);
    chk("rel_halt", 32'(halt_req), 32'd0);
    chk("rel_cnt", cycle_cnt, 32'd0);

    send(CmdHalt, 2'b11, 8'd0);
    chk("halt11", 32'(halt_req), 32'd3);
    send(CmdResume, 2'b01, 8'd0);
    chk("resume01", 32'(halt_req), 32'd2);
    send(CmdHalt, 2'b11, 8'd0);
    chk("rehalt11", 32'(halt_req), 32'd3);

    send(CmdStep, 2'b01, 8'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("step_halt_%0d", i), 32'(halt_req), 32'd2);
      chk($sformatf("step_ready_%0d", i), 32'(cmd_ready), 32'd0);
      tick();
    end
    chk("step_end_halt", 32'(halt_req), 32'd3);
    chk("step_end_ready", 32'(cmd_ready), 32'd1);
    chk("step_end_busy", 32'(busy), 32'd0);

    send(CmdStep, 2'b11, 8'd0);
    chk("step0_halt", 32'(halt_req), 32'd3);
    chk("step0_ready", 32'(cmd_ready), 32'd1);
    chk("run_cnt", cycle_cnt, 32'd10);

    // Watchdog expiry, DONE behaviour, RESET out of DONE
    rst = 1'b1;
    tick();
    chk_reset_vals("rst2");
    rst = 1'b0;
    wait_release(n);
    chk("hold_len2", 32'(n), 32'd10);
    n = 0;
    while (!timeout && n < 100) begin
      n++;
      tick();
    end
    chk("wd_cycles", 32'(n), 32'd20);
    chk("wd_cnt", cycle_cnt, 32'd20);
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_halt", 32'(halt_req), 32'd3);
    chk("wd_busy", 32'(busy), 32'd1);
    chk("wd_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("wd_cnt_hold", cycle_cnt, 32'd20);
    send(CmdResume, 2'b11, 8'd0);
    chk("done_resume", 32'(halt_req), 32'd3);
    send(CmdStep, 2'b01, 8'd3);
    chk("done_step_halt", 32'(halt_req), 32'd3);
    chk("done_step_ready", 32'(cmd_ready), 32'd1);
    chk("done_cnt", cycle_cnt, 32'd20);
    send(CmdReset, 2'b00, 8'd0);
    chk("dreset_core_rst", 32'(core_rst), 32'd1);
    chk("dreset_cnt", cycle_cnt, 32'd0);
    chk("dreset_timeout", 32'(timeout), 32'd1);
    chk("dreset_halt", 32'(halt_req), 32'd0);
    wait_release(n);
    chk("dreset_hold_len", 32'(n), 32'd10);
    chk("dreset_ready", 32'(cmd_ready), 32'd1);
    chk("dreset_busy", 32'(busy), 32'd0);
    chk("dreset_timeout2", 32'(timeout), 32'd1);

    // rst in the middle of a long step
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_release(n);
    send(CmdHalt, 2'b11, 8'd0);
    send(CmdStep, 2'b01, 8'd100);
    repeat (9) tick();
    chk("midstep_halt", 32'(halt_req), 32'd2);
    chk("midstep_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    wait_release(n);
    chk("midrst_hold_len", 32'(n), 32'd10);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (halt_req != 2'b00 || !cmd_ready) bad++;
      tick();
    end
    chk("no_late_rehalt", 32'(bad), 32'd0);
    chk("post_cnt", cycle_cnt, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
